// File: rtl/mul_arbiter_rr.sv
// Round-robin arbiter sharing one MUL_LAT-stage unsigned multiplier among NUM_REQ requesters.
// Optional statistics counters are built only when MUL_ARB_STATS_EN is defined.
module mul_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 24,
  parameter int B_W     = 37,
  parameter int P_W     = 60,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  output logic                   busy,
  input  logic                   stat_clr,
  output logic [31:0]            stat_issue_cnt,
  output logic [31:0]            stat_stall_cnt
);

  logic                          advance_s;
  logic                          accept_s;
  logic                          grant_found_s;
  logic                          hit_s;
  logic [ID_W-1:0]               grant_idx_s;
  logic [ID_W:0]                 cand_s;
  logic [A_W-1:0]                a_sel_s;
  logic [B_W-1:0]                b_sel_s;
  logic [P_W-1:0]                mul_s;
  logic [ID_W-1:0]               ptr_q;
  logic [ID_W-1:0]               ptr_d;
  logic [MUL_LAT-1:0]            vld_q;
  logic [MUL_LAT-1:0]            vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0]  id_q;
  logic [MUL_LAT-1:0][ID_W-1:0]  id_d;
  logic [MUL_LAT-1:0][P_W-1:0]   prod_q;
  logic [MUL_LAT-1:0][P_W-1:0]   prod_d;

  assign rsp_valid = vld_q[MUL_LAT-1];
  assign rsp_id    = id_q[MUL_LAT-1];
  assign rsp_data  = prod_q[MUL_LAT-1];
  assign busy      = |vld_q;
  assign advance_s = ~(rsp_valid & ~rsp_ready);
  assign accept_s  = grant_found_s & advance_s & ap_rst_n;

  // Rotating priority search starting at ptr; the first valid candidate wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s        = {1'b0, ptr_q} + (ID_W+1)'(k);
      cand_s        = (cand_s >= (ID_W+1)'(NUM_REQ)) ? cand_s - (ID_W+1)'(NUM_REQ) : cand_s;
      hit_s         = req_valid[cand_s[ID_W-1:0]] & ~grant_found_s;
      grant_idx_s   = hit_s ? cand_s[ID_W-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Ready is one-hot on the winner and only while the pipeline can move.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand select and multiply; P_W-bit arithmetic keeps exactly the low P_W product bits.
  always_comb begin
    a_sel_s = req_a[int'(grant_idx_s)*A_W +: A_W];
    b_sel_s = req_b[int'(grant_idx_s)*B_W +: B_W];
    mul_s   = P_W'(a_sel_s) * P_W'(b_sel_s);
  end

  // Pipeline and pointer next state; everything holds while the output is stalled.
  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    prod_d = prod_q;
    ptr_d  = ptr_q;
    if (advance_s) begin
      for (int s = MUL_LAT - 1; s > 0; s--) begin
        vld_d[s]  = vld_q[s-1];
        id_d[s]   = id_q[s-1];
        prod_d[s] = prod_q[s-1];
      end
      vld_d[0] = accept_s;
      if (accept_s) begin
        id_d[0]   = grant_idx_s;
        prod_d[0] = mul_s;
        ptr_d     = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
      end else begin
        id_d[0]   = id_q[0];
        prod_d[0] = prod_q[0];
        ptr_d     = ptr_q;
      end
    end else begin
      vld_d  = vld_q;
      id_d   = id_q;
      prod_d = prod_q;
      ptr_d  = ptr_q;
    end
  end

  // Pipeline and pointer state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      id_q   <= '0;
      prod_q <= '0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      prod_q <= prod_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef MUL_ARB_STATS_EN
  logic        stall_s;
  logic [31:0] issue_cnt_q;
  logic [31:0] issue_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign stall_s = rsp_valid & ~rsp_ready;

  // Counter next state; clear beats increment.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      issue_cnt_d = 32'd0;
      stall_cnt_d = 32'd0;
    end else begin
      issue_cnt_d = sat_inc(issue_cnt_q, accept_s);
      stall_cnt_d = sat_inc(stall_cnt_q, stall_s);
    end
  end

  // Statistics counter state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      issue_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_issue_cnt = issue_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  // No counters: outputs are constant zero, the mask only keeps stat_clr referenced.
  assign stat_issue_cnt = {32{stat_clr}} & 32'h0000_0000;
  assign stat_stall_cnt = {32{stat_clr}} & 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mul_arbiter_rr.sv
// Self-checking bench for mul_arbiter_rr: directed steps followed by randomized traffic,
// compared against a transaction-level model (queue of in-flight results with ages).
module tb_mul_arbiter_rr;
  localparam int NUM_REQ = 4;
  localparam int A_W     = 24;
  localparam int B_W     = 37;
  localparam int P_W     = 60;
  localparam int MUL_LAT = 2;
  localparam int ID_W    = 2;
`ifdef MUL_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic                   ap_clk = 1'b0;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_data;
  logic                   busy;
  logic                   stat_clr;
  logic [31:0]            stat_issue_cnt;
  logic [31:0]            stat_stall_cnt;

  always #5 ap_clk = ~ap_clk;

  mul_arbiter_rr #(
    .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT), .ID_W(ID_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .stat_clr(stat_clr),
    .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  typedef struct {
    int             id;
    logic [P_W-1:0] prod;
    int             age;
  } ent_t;

  ent_t               pipe_q[$];
  int                 ptr_m;
  logic [31:0]        issue_m;
  logic [31:0]        stall_m;
  int                 checks   = 0;
  int                 failures = 0;
  logic               acc_m;
  int                 g_m;
  logic [NUM_REQ-1:0] obs_ready;
  bit                 continuous;
  logic [A_W-1:0]     pa [NUM_REQ];
  logic [B_W-1:0]     pb [NUM_REQ];
  logic               pv [NUM_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_rsp_valid();
    return (pipe_q.size() > 0) && (pipe_q[0].age == MUL_LAT - 1);
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    ptr_m   = 0;
    issue_m = 32'd0;
    stall_m = 32'd0;
  endtask

  task automatic new_operands(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 9) == 0) begin
      pa[i] = {A_W{1'b1}};
      pb[i] = {B_W{1'b1}};
    end else begin
      pa[i] = r[A_W-1:0];
      pb[i] = r[63:64-B_W];
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = pv[i];
      req_a[i*A_W +: A_W]   = pa[i];
      req_b[i*B_W +: B_W]   = pb[i];
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model after the rising edge.
  task automatic tick();
    logic               rv;
    logic               adv;
    logic               any;
    int                 g;
    int                 idx;
    logic [NUM_REQ-1:0] exp_ready;
    logic [63:0]        full;
    ent_t               e;
    @(negedge ap_clk);
    rv  = model_rsp_valid();
    adv = !(rv && !rsp_ready);
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ptr_m + k) % NUM_REQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    exp_ready = (any && adv) ? (NUM_REQ'(1) << g) : '0;
    obs_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, rv);
    chk("busy", busy, pipe_q.size() > 0);
    if (rv) begin
      chk("rsp_id", rsp_id, pipe_q[0].id);
      chk("rsp_data", rsp_data, pipe_q[0].prod);
    end
    chk("stat_issue_cnt", stat_issue_cnt, STATS_EN ? issue_m : 32'd0);
    chk("stat_stall_cnt", stat_stall_cnt, STATS_EN ? stall_m : 32'd0);
    acc_m  = any && adv;
    g_m    = g;
    full   = {40'd0, req_a[g*A_W +: A_W]} * {27'd0, req_b[g*B_W +: B_W]};
    e.id   = g;
    e.prod = full[P_W-1:0];
    e.age  = 0;
    @(posedge ap_clk);
    #1;
    if (stat_clr) begin
      issue_m = 32'd0;
      stall_m = 32'd0;
    end else begin
      if (acc_m) issue_m = issue_m + 32'd1;
      if (rv && !rsp_ready) stall_m = stall_m + 32'd1;
    end
    if (adv) begin
      if (rv) void'(pipe_q.pop_front());
      foreach (pipe_q[i]) pipe_q[i].age = pipe_q[i].age + 1;
      if (acc_m) begin
        pipe_q.push_back(e);
        ptr_m = (g + 1) % NUM_REQ;
      end
    end
    if (acc_m) begin
      if (continuous) new_operands(g_m);
      else pv[g_m] = 1'b0;
    end
    drive_reqs();
  endtask

  int          rr_order [6] = '{0, 1, 2, 3, 0, 1};
  logic [P_W-1:0] data_hold;

  initial begin
    ap_rst_n   = 1'b0;
    rsp_ready  = 1'b1;
    stat_clr   = 1'b0;
    continuous = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pv[i] = 1'b1;
      new_operands(i);
    end
    drive_reqs();
    model_reset();

    // Reset held with every requester valid.
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_data", rsp_data, 60'd0);
    chk("rst_issue", stat_issue_cnt, 32'd0);
    ap_rst_n = 1'b1;

    // Round-robin with all requesters continuously valid.
    for (int i = 0; i < 6; i++) begin
      stat_clr = (i == 5);
      tick();
      chk("rr_order", obs_ready, NUM_REQ'(1) << rr_order[i]);
    end
    stat_clr = 1'b0;

    // Backpressure with the pipeline full.
    data_hold = rsp_data;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", obs_ready, 4'b0000);
      chk("bp_hold", rsp_data, data_hold);
    end
    chk("bp_stall_cnt", stat_stall_cnt, STATS_EN ? 32'd3 : 32'd0);
    rsp_ready  = 1'b1;
    continuous = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    drive_reqs();
    repeat (4) tick();

    // Single request: requester 2, 3*5.
    pv[2] = 1'b1; pa[2] = 24'd3; pb[2] = 37'd5;
    drive_reqs();
    tick();
    tick();
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, 2'd2);
    chk("single_data", rsp_data, 60'd15);
    tick();

    // Width edge: all-ones operands.
    pv[1] = 1'b1; pa[1] = 24'hFF_FFFF; pb[1] = 37'h1F_FFFF_FFFF;
    drive_reqs();
    tick();
    tick();
    chk("edge_valid", rsp_valid, 1'b1);
    chk("edge_data", rsp_data, 60'hFFF_FFDF_FF00_0001);
    tick();

    // Mid-flight reset with two results in the pipeline.
    for (int i = 0; i < NUM_REQ; i++) begin
      pv[i] = 1'b1;
      new_operands(i);
    end
    drive_reqs();
    tick();
    tick();
    ap_rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_req_ready", req_ready, 4'b0000);
    #2;
    ap_rst_n = 1'b1;
    model_reset();
    tick();
    chk("mrst_first_grant", obs_ready, 4'b0001);
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    drive_reqs();
    repeat (4) tick();

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 99) < 40)) begin
          pv[i] = 1'b1;
          new_operands(i);
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      stat_clr  = ($urandom_range(0, 99) < 3);
      drive_reqs();
      tick();
    end
    stat_clr  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    drive_reqs();
    repeat (6) tick();
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_arbiter_rr.md
# mul_arbiter_rr

Round-robin arbiter and pipeline controller that shares one unsigned 24×37 multiplier among NUM_REQ requesters inside the MatrixMultiplicationKernel datapath. Each requester presents operand pairs on a valid/ready channel. Granted pairs are issued into a MUL_LAT-stage multiply pipeline tagged with the requester index. Results leave on one shared response channel carrying that tag; response backpressure freezes the whole pipeline through its clock enable.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- A_W, 24: operand A width.
- B_W, 37: operand B width.
- P_W, 60: product width; low P_W bits of the full A_W+B_W product.
- MUL_LAT, 2: multiply pipeline depth in registers; 1..4.
- ID_W, $clog2(NUM_REQ): tag width.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed operand A; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed operand B; requester i at [i*B_W +: B_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  requester index of the result.
- rsp_data  out  P_W  product.
- busy  out  1  any valid entry in the pipeline, including the output stage.
- stat_clr  in  1  synchronous clear of the statistics counters.
- stat_issue_cnt  out  32  accepted requests.
- stat_stall_cnt  out  32  cycles with rsp_valid=1 and rsp_ready=0.

## Operation
- advance = !(rsp_valid && !rsp_ready). This is the pipeline clock enable.
- Grant selection:
  - grant is the first index g with req_valid[g]=1, searching ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[g] = advance. All other bits of req_ready are 0.
  - req_ready is combinational from req_valid, ptr and rsp_ready.
- Accept is req_valid[g] && req_ready[g]. On accept:
  - stage 1 loads {valid=1, id=g, product=req_a[g]*req_b[g]}.
  - ptr <= (g+1) mod NUM_REQ.
- With no accept, ptr holds. When advance=1, stage 1 loads valid=0.
- Each stage holds valid, id and product. When advance=1, stage k+1 <= stage k. When advance=0, every stage holds, including ptr. Bubbles are not collapsed.
- Stage MUL_LAT drives rsp_valid, rsp_id and rsp_data.
- Arithmetic: unsigned. Bits above P_W are discarded, so max×max with the defaults keeps the low 60 of 61 bits.
- Requester contract: hold req_valid, req_a and req_b stable until accepted. A requester whose valid drops before acceptance simply loses grant eligibility; this is not an error.
- busy is the OR of all stage valid bits.

## Timing
- Reset (ap_rst_n=0, asynchronous):
  - all stage valid bits = 0, ptr = 0, stat counters = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - req_ready is driven 0 while reset is asserted.
- Latency: a request accepted at edge T is presented on rsp_valid after edge T+MUL_LAT−1, i.e. MUL_LAT cycles after the accept cycle, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one accept per cycle while rsp_ready=1.
- Simultaneous events: when rsp accept and new req accept occur in the same cycle, both happen; the output stage is replaced.
- Starvation bound: a continuously valid requester is accepted within NUM_REQ accept events.
- Reset mid-operation: in-flight results are dropped and no response is emitted for them. Requesters must re-present.
- Statistics:
  - stat_issue_cnt increments on each accept.
  - stat_stall_cnt increments on each stall cycle.
  - Both saturate at 2^32−1.
  - stat_clr has priority over increment in the same cycle.

## Configuration
- MUL_ARB_STATS_EN defined: the stat counters and stat_clr logic are built as described.
- Undefined: stat_issue_cnt and stat_stall_cnt are tied to 0, stat_clr is ignored, and no counter flops exist.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold ap_rst_n=0 with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0. Release: first accept is requester 0.
- Single request, MUL_LAT=2: req 2 presents a=3, b=5 at cycle 0 -> rsp_valid=1, rsp_id=2, rsp_data=15 at cycle 2.
- Round-robin: all four valid continuously with rsp_ready=1 -> accept order 0,1,2,3,0,1; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 3 cycles with the pipeline full -> pipeline frozen, req_ready=0, outputs stable. With MUL_ARB_STATS_EN, stat_stall_cnt=3. No result lost or duplicated after release.
- Width edge: a=24'hFFFFFF, b=37'h1FFFFFFFFF -> rsp_data = low 60 bits of the 61-bit product, = 60'hFFFFFDFFF000001.
- Mid-flight reset: assert ap_rst_n=0 with 2 results in flight -> rsp_valid drops immediately, busy=0, ptr=0, and no stale response after release.
